vga_sync_decoder: RTL and testbench

VGA_SYNC_DECODER -- requirements
Module: vga_sync_decoder

---
 rtl/vga_sync_decoder.sv | 176 +++++++++++++++++
 tb/tb_vga_sync_decoder.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: recovers active-area pixel coordinates from raw VGA syncs,
// measures line/frame lengths and tracks whether the incoming timing is stable.
module vga_sync_decoder #(
    parameter int unsigned H_TOTAL     = 800,
    parameter int unsigned H_SYNC      = 96,
    parameter int unsigned H_BP        = 48,
    parameter int unsigned H_ACTIVE    = 640,
    parameter int unsigned V_TOTAL     = 525,
    parameter int unsigned V_SYNC      = 2,
    parameter int unsigned V_BP        = 33,
    parameter int unsigned V_ACTIVE    = 480,
    parameter int unsigned LOCK_FRAMES = 2
) (
    input  logic       CLK,
    input  logic       ResetN,
    input  logic       HSYNC,
    input  logic       VSYNC,
    output logic [9:0] PixelX,
    output logic [9:0] LineY,
    output logic       DataValid,
    output logic       FrameStart,
    output logic       Locked,
    output logic       SyncErr,
    output logic [9:0] HTotal,
    output logic [9:0] VTotal
);

    localparam logic [9:0]  HStart = 10'(H_SYNC + H_BP);
    localparam logic [9:0]  HEnd   = 10'(H_SYNC + H_BP + H_ACTIVE - 1);
    localparam logic [9:0]  VStart = 10'(V_SYNC + V_BP);
    localparam logic [9:0]  VEnd   = 10'(V_SYNC + V_BP + V_ACTIVE - 1);
    localparam logic [10:0] HTot   = 11'(H_TOTAL);
    localparam logic [10:0] VTot   = 11'(V_TOTAL);
    localparam logic [7:0]  LockN  = 8'(LOCK_FRAMES);
    localparam logic [9:0]  CntMax = 10'h3FF;

    typedef enum logic [1:0] {StSearch, StCheck, StLocked} state_e;

    logic       hs_meta_q, hs_sync_q, hs_prev_q;
    logic       vs_meta_q, vs_sync_q, vs_prev_q;
    logic       vfall_q, vfall_d;
    logic [9:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
    logic [9:0] htotal_q, htotal_d, vtotal_q, vtotal_d;
    logic [9:0] pixel_x_q, pixel_x_d, line_y_q, line_y_d;
    logic       dv_q, dv_d, fs_q, fs_d, serr_q, serr_d;
    logic [7:0] good_cnt_q, good_cnt_d;
    state_e     state_q, state_d;

    logic        hfall, vs_fall, frame_start, line_bad, frame_bad, in_win;
    logic [10:0] hcnt_inc, vcnt_inc;

    // Edge detection and line/frame length measurement.
    always_comb begin
        hfall       = hs_prev_q & ~hs_sync_q;
        vs_fall     = vs_prev_q & ~vs_sync_q;
        frame_start = hfall & vfall_q;
        hcnt_inc    = {1'b0, hcnt_q} + 11'd1;
        vcnt_inc    = {1'b0, vcnt_q} + 11'd1;
        // A missing HSYNC is flagged once, on the cycle hcnt reaches saturation.
        line_bad    = (hfall && (hcnt_inc != HTot)) || (!hfall && (hcnt_q == CntMax - 10'd1));
        frame_bad   = frame_start && (vcnt_inc != VTot);

        vfall_d  = vs_fall | (vfall_q & ~hfall);
        fs_d     = frame_start;
        hcnt_d   = hfall ? 10'd0 : ((hcnt_q == CntMax) ? hcnt_q : hcnt_inc[9:0]);
        // Reported lengths saturate so a lost sync reads as 1023 rather than wrapping.
        htotal_d = hfall ? (hcnt_inc[10] ? CntMax : hcnt_inc[9:0]) : htotal_q;
        vcnt_d   = vcnt_q;
        vtotal_d = vtotal_q;
        if (hfall) begin
            if (vfall_q) begin
                vcnt_d   = 10'd0;
                vtotal_d = vcnt_inc[10] ? CntMax : vcnt_inc[9:0];
            end else begin
                vcnt_d = (vcnt_q == CntMax) ? vcnt_q : vcnt_inc[9:0];
            end
        end
    end

    // Lock FSM: next state, good-frame counter and error pulse.
    always_comb begin
        state_d    = state_q;
        good_cnt_d = good_cnt_q;
        serr_d     = 1'b0;
        unique case (state_q)
            StSearch: begin
                if (frame_start) begin
                    state_d    = StCheck;
                    good_cnt_d = 8'd0;
                end
            end
            StCheck: begin
                if (line_bad || frame_bad) begin
                    state_d    = StSearch;
                    good_cnt_d = 8'd0;
                end else if (frame_start) begin
                    good_cnt_d = good_cnt_q + 8'd1;
                    if (good_cnt_q + 8'd1 >= LockN) begin
                        state_d = StLocked;
                    end
                end
            end
            StLocked: begin
                if (line_bad || frame_bad) begin
                    serr_d     = 1'b1;
                    state_d    = StSearch;
                    good_cnt_d = 8'd0;
                end
            end
            default: state_d = StSearch;
        endcase
    end

    // Registered pixel outputs track the next counter values so they align with hcnt/vcnt.
    always_comb begin
        in_win = (state_d == StLocked) &&
                 (hcnt_d >= HStart) && (hcnt_d <= HEnd) &&
                 (vcnt_d >= VStart) && (vcnt_d <= VEnd);
        dv_d      = in_win;
        pixel_x_d = in_win ? (hcnt_d - HStart) : 10'd0;
        line_y_d  = in_win ? (vcnt_d - VStart) : 10'd0;
    end

    // All state: synchronizers, counters, measurements, FSM and registered outputs.
    always_ff @(posedge CLK or negedge ResetN) begin
        if (!ResetN) begin
            hs_meta_q  <= 1'b0;
            hs_sync_q  <= 1'b0;
            hs_prev_q  <= 1'b0;
            vs_meta_q  <= 1'b0;
            vs_sync_q  <= 1'b0;
            vs_prev_q  <= 1'b0;
            vfall_q    <= 1'b0;
            hcnt_q     <= 10'd0;
            vcnt_q     <= 10'd0;
            htotal_q   <= 10'd0;
            vtotal_q   <= 10'd0;
            pixel_x_q  <= 10'd0;
            line_y_q   <= 10'd0;
            dv_q       <= 1'b0;
            fs_q       <= 1'b0;
            serr_q     <= 1'b0;
            good_cnt_q <= 8'd0;
            state_q    <= StSearch;
        end else begin
            hs_meta_q  <= HSYNC;
            hs_sync_q  <= hs_meta_q;
            hs_prev_q  <= hs_sync_q;
            vs_meta_q  <= VSYNC;
            vs_sync_q  <= vs_meta_q;
            vs_prev_q  <= vs_sync_q;
            vfall_q    <= vfall_d;
            hcnt_q     <= hcnt_d;
            vcnt_q     <= vcnt_d;
            htotal_q   <= htotal_d;
            vtotal_q   <= vtotal_d;
            pixel_x_q  <= pixel_x_d;
            line_y_q   <= line_y_d;
            dv_q       <= dv_d;
            fs_q       <= fs_d;
            serr_q     <= serr_d;
            good_cnt_q <= good_cnt_d;
            state_q    <= state_d;
        end
    end

    assign PixelX     = pixel_x_q;
    assign LineY      = line_y_q;
    assign DataValid  = dv_q;
    assign FrameStart = fs_q;
    assign SyncErr    = serr_q;
    assign Locked     = (state_q == StLocked);
    assign HTotal     = htotal_q;
    assign VTotal     = vtotal_q;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Bench for vga_sync_decoder: small timing parameters, randomized line/frame faults,
// frame-level reference model feeding scoreboards checked by an independent monitor.
module tb_vga_sync_decoder;

    localparam int HT = 40, HS = 4, HBP = 6, HA = 24;
    localparam int VT = 20, VS = 2, VBP = 3, VA = 12;
    localparam int LF = 2;
    localparam int HSTART = HS + HBP;
    localparam int VSTART = VS + VBP;

    logic       CLK = 1'b0;
    logic       ResetN = 1'b1;
    logic       HSYNC = 1'b1;
    logic       VSYNC = 1'b1;
    logic [9:0] PixelX, LineY, HTotal, VTotal;
    logic       DataValid, FrameStart, Locked, SyncErr;

    vga_sync_decoder #(
        .H_TOTAL(HT), .H_SYNC(HS), .H_BP(HBP), .H_ACTIVE(HA),
        .V_TOTAL(VT), .V_SYNC(VS), .V_BP(VBP), .V_ACTIVE(VA), .LOCK_FRAMES(LF)
    ) dut (
        .CLK(CLK), .ResetN(ResetN), .HSYNC(HSYNC), .VSYNC(VSYNC),
        .PixelX(PixelX), .LineY(LineY), .DataValid(DataValid), .FrameStart(FrameStart),
        .Locked(Locked), .SyncErr(SyncErr), .HTotal(HTotal), .VTotal(VTotal)
    );

    always #5 CLK = ~CLK;

    int unsigned cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct { bit chk; int htot; int vtot; bit locked; } fs_rec_t;
    typedef struct { int x; int y; } pix_t;
    fs_rec_t fs_q[$];
    pix_t    pix_q[$];

    int tests = 0, fails = 0;
    int se_seen = 0, se_exp = 0;
    int unsigned hs_fall_cyc = 0;

    // Frame-level reference model: 0 = searching, 1 = checking, 2 = locked.
    int m_st = 0, m_cnt = 0;
    bit m_first = 1'b1;
    int prev_lines = 0, prev_last_len = 0;
    int vs_low = 0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Frame start ending the previous frame: queue what the DUT must report.
    task automatic frame_boundary();
        fs_rec_t r;
        r.chk  = !m_first;
        r.htot = prev_last_len;
        r.vtot = prev_lines;
        if (m_st == 0) begin
            m_st  = 1;
            m_cnt = 0;
        end else if (m_st == 1) begin
            if (prev_lines == VT) begin
                m_cnt++;
                if (m_cnt >= LF) m_st = 2;
            end else begin
                m_st = 0;
            end
        end else if (prev_lines != VT) begin
            se_exp++;
            m_st = 0;
        end
        r.locked = (m_st == 2);
        fs_q.push_back(r);
        m_first = 1'b0;
    endtask

    task automatic drive_line(input int len, input int vfall_pos, input bit vis, input int row,
                              input int stop_at);
        pix_t p;
        if (vis && row >= VSTART && row < VSTART + VA) begin
            for (int x = 0; x < HA; x++) begin
                p.x = x;
                p.y = row - VSTART;
                pix_q.push_back(p);
            end
        end
        for (int c = 0; c < stop_at; c++) begin
            @(negedge CLK);
            HSYNC = (c < HS) ? 1'b0 : 1'b1;
            if (c == 0) hs_fall_cyc = cyc;
            if (c == vfall_pos) vs_low = VS * HT;
            VSYNC = (vs_low > 0) ? 1'b0 : 1'b1;
            if (vs_low > 0) vs_low--;
        end
    endtask

    task automatic drive_frame(input int nlines, input int bad_idx, input int bad_len);
        int len, prev_len;
        check("syncerr_count", se_seen, se_exp);
        frame_boundary();
        prev_len = HT;
        len = HT;
        for (int i = 0; i < nlines; i++) begin
            len = (i == bad_idx) ? bad_len : HT;
            drive_line(len, (i == nlines - 1) ? int'($urandom_range(len - 4, HS)) : -1,
                       m_st == 2, i, len);
            if (i > 0) check("htotal_line", int'(HTotal), (prev_len > 1023) ? 1023 : prev_len);
            if (len != HT && m_st != 0) begin
                if (m_st == 2) se_exp++;
                m_st = 0;
            end
            prev_len = len;
        end
        prev_lines    = nlines;
        prev_last_len = len;
    endtask

    // One line carrying a VSYNC fall so the next line opens a frame.
    task automatic preamble();
        m_first = 1'b1;
        drive_line(HT, HS + 5, 1'b0, 0, HT);
    endtask

    task automatic reset_mid_line();
        check("syncerr_count", se_seen, se_exp);
        frame_boundary();
        for (int i = 0; i < VSTART + 2; i++) drive_line(HT, -1, m_st == 2, i, HT);
        drive_line(HT, -1, m_st == 2, VSTART + 2, HSTART + 8);
        check("locked_before_reset", Locked, 1);
        check("dv_before_reset", DataValid, 1);
        #2 ResetN = 1'b0;
        #1;
        check("arst_dv", DataValid, 0);
        check("arst_pixelx", int'(PixelX), 0);
        check("arst_liney", int'(LineY), 0);
        check("arst_locked", Locked, 0);
        check("arst_fs", FrameStart, 0);
        check("arst_syncerr", SyncErr, 0);
        check("arst_htotal", int'(HTotal), 0);
        check("arst_vtotal", int'(VTotal), 0);
        fs_q.delete();
        pix_q.delete();
        m_st   = 0;
        m_cnt  = 0;
        vs_low = 0;
        HSYNC  = 1'b1;
        VSYNC  = 1'b1;
        repeat (3) @(negedge CLK);
        ResetN = 1'b1;
        repeat (2) @(negedge CLK);
    endtask

    function automatic int pick_bad();
        return int'($urandom_range(VT - 3, 1));
    endfunction

    // Monitor: pops expectations whenever the DUT presents a frame start or a pixel.
    initial begin
        fs_rec_t r;
        pix_t    p;
        bit      dv_prev;
        dv_prev = 1'b0;
        forever begin
            @(negedge CLK);
            if (ResetN) begin
                if (FrameStart) begin
                    if (fs_q.size() == 0) begin
                        check("fs_unexpected", FrameStart, 0);
                    end else begin
                        r = fs_q.pop_front();
                        check("locked_at_fs", Locked, r.locked);
                        if (r.chk) begin
                            check("htotal_at_fs", int'(HTotal), r.htot);
                            check("vtotal_at_fs", int'(VTotal), r.vtot);
                        end
                    end
                end
                if (DataValid) begin
                    if (pix_q.size() == 0) begin
                        check("dv_unexpected", DataValid, 0);
                    end else begin
                        p = pix_q.pop_front();
                        check("pixel_x", int'(PixelX), p.x);
                        check("line_y", int'(LineY), p.y);
                    end
                    if (!dv_prev) check("dv_latency", int'(cyc - hs_fall_cyc), 3 + HSTART);
                end
                if (SyncErr) se_seen++;
            end
            dv_prev = DataValid;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int dev, fdev;
        #1 ResetN = 1'b0;
        repeat (3) @(negedge CLK);
        check("rst_dv", DataValid, 0);
        check("rst_pixelx", int'(PixelX), 0);
        check("rst_liney", int'(LineY), 0);
        check("rst_fs", FrameStart, 0);
        check("rst_locked", Locked, 0);
        check("rst_syncerr", SyncErr, 0);
        check("rst_htotal", int'(HTotal), 0);
        check("rst_vtotal", int'(VTotal), 0);
        ResetN = 1'b1;
        repeat (2) @(negedge CLK);

        // Clean timing from reset: lock at the third frame start.
        preamble();
        repeat (4) drive_frame(VT, -1, HT);

        // One line a clock short while locked, then relock.
        drive_frame(VT, pick_bad(), HT - 1);
        repeat (3) drive_frame(VT, -1, HT);

        // Random short/long lines.
        for (int k = 0; k < 2; k++) begin
            dev = int'($urandom_range(3, 1));
            if ($urandom_range(1, 0) == 1) dev = -dev;
            drive_frame(VT, pick_bad(), HT + dev);
            repeat (3) drive_frame(VT, -1, HT);
        end

        // Missing HSYNC: counter saturates, lock drops.
        drive_frame(VT, pick_bad(), HS + 1100);
        repeat (3) drive_frame(VT, -1, HT);

        // Wrong frame length while locked, then a short frame while checking.
        fdev = ($urandom_range(1, 0) == 1) ? 1 : -1;
        drive_frame(VT + fdev, -1, HT);
        drive_frame(VT, -1, HT);
        drive_frame(VT - 1, -1, HT);
        repeat (4) drive_frame(VT, -1, HT);

        // Asynchronous reset mid-line while locked, then full relock.
        reset_mid_line();
        preamble();
        repeat (4) drive_frame(VT, -1, HT);

        // Closing frame start so the last frame's report is seen.
        check("syncerr_count", se_seen, se_exp);
        frame_boundary();
        drive_line(HT, -1, m_st == 2, 0, HT);
        repeat (10) @(negedge CLK);
        check("fs_queue_drained", fs_q.size(), 0);
        check("pix_queue_drained", pix_q.size(), 0);
        check("syncerr_total", se_seen, se_exp);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
